// File: rtl/fifo_checker.sv
// fifo_checker: passive, synthesizable scoreboard for a ready/valid FIFO.
// Snoops the enqueue and dequeue handshakes of a neighbouring FIFO, keeps a
// shadow copy of its contents and reports reset, data and protocol errors
// through one-cycle pulses, saturating counters, occupancy coverage bitmaps
// and a first-error capture with a cycle timestamp.
module fifo_checker #(
    parameter int WIDTH_P        = 8,
    parameter int CAP_P          = 8,
    parameter int CNT_W_P        = 16,
    parameter int CYC_W_P        = 32,
    parameter int STRICT_READY_P = 0
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     clear_i,
    input  logic                     valid_i,
    input  logic [WIDTH_P-1:0]       data_i,
    input  logic                     ready_o,
    input  logic                     valid_o,
    input  logic [WIDTH_P-1:0]       data_o,
    input  logic                     yumi_i,
    output logic [$clog2(CAP_P):0]   occupancy_out,
    output logic                     err_reset_out,
    output logic                     err_data_out,
    output logic                     err_proto_out,
    output logic [CNT_W_P-1:0]       cnt_reset_out,
    output logic [CNT_W_P-1:0]       cnt_data_out,
    output logic [CNT_W_P-1:0]       cnt_proto_out,
    output logic [CAP_P-1:0]         enq_cov_out,
    output logic [CAP_P-1:0]         deq_cov_out,
    output logic [CAP_P-2:0]         both_cov_out,
    output logic                     first_err_valid_out,
    output logic [1:0]               first_err_code_out,
    output logic [CYC_W_P-1:0]       first_err_cycle_out
);

    localparam int PTR_W = $clog2(CAP_P);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(CAP_P);

    // Shadow queue state
    logic [WIDTH_P-1:0] mem_q [CAP_P];
    logic [PTR_W-1:0]   head_q, tail_q;
    logic [OCC_W-1:0]   occ_q, occ_d;

    // Cycle tracking; started_q is low only until the first edge after reset
    logic               started_q;
    logic [CYC_W_P-1:0] cyc_q, cyc_d;

    // Error reporting state
    logic               err_reset_q, err_data_q, err_proto_q;
    logic [CNT_W_P-1:0] cnt_reset_q, cnt_data_q, cnt_proto_q;
    logic [CAP_P-1:0]   enq_cov_q, deq_cov_q;
    logic [CAP_P-2:0]   both_cov_q;
    logic               fe_valid_q;
    logic [1:0]         fe_code_q, fe_code_d;
    logic [CYC_W_P-1:0] fe_cycle_q;

    // Edge events
    logic enq, deq, is_full, is_empty, do_push, do_pop;
    logic enq_only, deq_only, enq_deq;
    logic strict_bad;
    logic err_reset_d, err_data_d, err_proto_d, any_err;
    logic [WIDTH_P-1:0] head_data;
    logic [CAP_P-1:0]   enq_set, deq_set;
    logic [CAP_P-2:0]   both_set;

    function automatic logic [CNT_W_P-1:0] sat_inc(input logic [CNT_W_P-1:0] v,
                                                   input logic en);
        logic [CNT_W_P-1:0] r;
        if (en && (v != {CNT_W_P{1'b1}})) r = v + 1'b1;
        else                               r = v;
        return r;
    endfunction

    assign enq       = valid_i & ready_o;
    assign deq       = valid_o & yumi_i;
    assign is_full   = (occ_q == FULL_OCC);
    assign is_empty  = (occ_q == '0);
    assign do_push   = enq & ~is_full;     // overflowing writes are dropped
    assign do_pop    = deq & ~is_empty;    // underflowing reads do not pop
    assign enq_only  = enq & ~deq;
    assign deq_only  = deq & ~enq;
    assign enq_deq   = enq & deq;
    assign head_data = mem_q[head_q];

    // ready must equal "not full" on every edge when the strict option is set
    assign strict_bad  = (STRICT_READY_P != 0) & (ready_o == is_full);
    assign err_reset_d = ~started_q & (~ready_o | valid_o);
    assign err_data_d  = do_pop & (data_o != head_data);
    assign err_proto_d = (enq & is_full) | (deq & is_empty) | strict_bad;
    assign any_err     = err_reset_d | err_data_d | err_proto_d;

    // Same-edge priority: reset, then data, then protocol
    assign fe_code_d = err_reset_d ? 2'b01 : (err_data_d ? 2'b10 : 2'b11);

    assign occ_d = occ_q + OCC_W'(do_push) - OCC_W'(do_pop);
    assign cyc_d = (cyc_q == {CYC_W_P{1'b1}}) ? cyc_q : cyc_q + 1'b1;

    // Occupancy decode for coverage; overflow/underflow occupancies are simply
    // outside each decode range, and a data mismatch suppresses its bit.
    for (genvar gi = 0; gi < CAP_P; gi++) begin : g_cov
        assign enq_set[gi] = enq_only & (occ_q == OCC_W'(gi));
        assign deq_set[gi] = deq_only & ~err_data_d & (occ_q == OCC_W'(gi + 1));
    end
    for (genvar gi = 0; gi < CAP_P - 1; gi++) begin : g_both
        assign both_set[gi] = enq_deq & ~err_data_d & (occ_q == OCC_W'(gi + 1));
    end

    // Shadow queue: compare/pop at the head, push at the tail; clear_i does not touch it
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < CAP_P; i++) mem_q[i] <= '0;
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[tail_q] <= data_i;
                tail_q        <= tail_q + 1'b1;
            end
            if (do_pop) head_q <= head_q + 1'b1;
            occ_q <= occ_d;
        end
    end

    // Cycle counter and the one-shot flag that arms the reset check
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            started_q <= 1'b0;
            cyc_q     <= '0;
        end else begin
            started_q <= 1'b1;
            cyc_q     <= cyc_d;
        end
    end

    // Error pulses, saturating counters and first-error capture
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            err_reset_q <= 1'b0;
            err_data_q  <= 1'b0;
            err_proto_q <= 1'b0;
            cnt_reset_q <= '0;
            cnt_data_q  <= '0;
            cnt_proto_q <= '0;
            fe_valid_q  <= 1'b0;
            fe_code_q   <= '0;
            fe_cycle_q  <= '0;
        end else if (clear_i) begin
            err_reset_q <= 1'b0;
            err_data_q  <= 1'b0;
            err_proto_q <= 1'b0;
            cnt_reset_q <= '0;
            cnt_data_q  <= '0;
            cnt_proto_q <= '0;
            fe_valid_q  <= 1'b0;
            fe_code_q   <= '0;
            fe_cycle_q  <= '0;
        end else begin
            err_reset_q <= err_reset_d;
            err_data_q  <= err_data_d;
            err_proto_q <= err_proto_d;
            cnt_reset_q <= sat_inc(cnt_reset_q, err_reset_d);
            cnt_data_q  <= sat_inc(cnt_data_q, err_data_d);
            cnt_proto_q <= sat_inc(cnt_proto_q, err_proto_d);
            if (!fe_valid_q && any_err) begin
                fe_valid_q <= 1'b1;
                fe_code_q  <= fe_code_d;
                fe_cycle_q <= cyc_q;
            end
        end
    end

    // Sticky occupancy coverage bitmaps
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            enq_cov_q  <= '0;
            deq_cov_q  <= '0;
            both_cov_q <= '0;
        end else if (clear_i) begin
            enq_cov_q  <= '0;
            deq_cov_q  <= '0;
            both_cov_q <= '0;
        end else begin
            enq_cov_q  <= enq_cov_q | enq_set;
            deq_cov_q  <= deq_cov_q | deq_set;
            both_cov_q <= both_cov_q | both_set;
        end
    end

    assign occupancy_out       = occ_q;
    assign err_reset_out       = err_reset_q;
    assign err_data_out        = err_data_q;
    assign err_proto_out       = err_proto_q;
    assign cnt_reset_out       = cnt_reset_q;
    assign cnt_data_out        = cnt_data_q;
    assign cnt_proto_out       = cnt_proto_q;
    assign enq_cov_out         = enq_cov_q;
    assign deq_cov_out         = deq_cov_q;
    assign both_cov_out        = both_cov_q;
    assign first_err_valid_out = fe_valid_q;
    assign first_err_code_out  = fe_code_q;
    assign first_err_cycle_out = fe_cycle_q;

endmodule
